// File: rtl/cgra_seq_pkg.sv
// Shared types and helpers for the per-PE config-memory sequencer.
package cgra_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_ARM  = 2'd1,
    SEQ_RUN  = 2'd2,
    SEQ_DONE = 2'd3
  } seq_state_t;

  // Width used for zero-extended address compares against loop_end.
  localparam int unsigned CMP_W = 32;

  // True when the address has reached or passed the last body address.
  function automatic logic addr_ge_end(input logic [CMP_W-1:0] addr,
                                       input logic [CMP_W-1:0] loop_end);
    return addr >= loop_end;
  endfunction

  // True when the address sits exactly on the last body address.
  function automatic logic addr_eq_end(input logic [CMP_W-1:0] addr,
                                       input logic [CMP_W-1:0] loop_end);
    return addr == loop_end;
  endfunction

endpackage

// File: rtl/cmem_sequencer_start_shifter.sv
// Delay line for the start request, with enable and synchronous clear.
module start_shifter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic last_in_c
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;
  logic [DEPTH-1:0] shifted_c;

  // Contents after one shift; a single-stage line just takes din.
  if (DEPTH == 1) begin : g_one
    assign shifted_c = din;
  end else begin : g_multi
    assign shifted_c = {sr_q[DEPTH-2:0], din};
  end

  // Value the last stage is about to load, used to time the ARM->RUN step.
  assign last_in_c = shifted_c[DEPTH-1];
  assign dout      = sr_q[DEPTH-1];

  // Next contents: hold when disabled, clear wins over shift.
  always_comb begin
    sr_d = sr_q;
    if (en) begin
      if (clr) begin
        sr_d = '0;
      end else begin
        sr_d = shifted_c;
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/cmem_sequencer.sv
// Config-memory sequencer: delayed start, vector lane counter, clock enable
// and loop-body address walk feeding the iteration counter.
module cmem_sequencer
  import cgra_seq_pkg::*;
#(
  parameter int unsigned CONFIG_MEM_BITS = 3,
  parameter int unsigned VEC_WIDTH       = 4,
  parameter int unsigned START_DELAY     = 2,
  localparam int unsigned VEC_WIDTH_BITS = $clog2(VEC_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       chip_en,
  input  logic                       start_exec,
  input  logic [CONFIG_MEM_BITS:0]   loop_start,
  input  logic [CONFIG_MEM_BITS-1:0] loop_end,
  input  logic [VEC_WIDTH_BITS-1:0]  vec_size,
  input  logic                       exec_end,
  output logic                       start_exec_shifted,
  output logic [VEC_WIDTH_BITS-1:0]  vec_counter,
  output logic                       clken_vec,
  output logic [CONFIG_MEM_BITS:0]   addr_cmem,
  output logic                       loop_wrap,
  output logic                       done
);

  localparam int unsigned ADDR_W = CONFIG_MEM_BITS + 1;

  seq_state_t                state_q, state_d;
  logic [VEC_WIDTH_BITS-1:0] vec_q, vec_d;
  logic                      clken_q, clken_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      wrap_q, wrap_d;
  logic                      done_q, done_d;
  logic                      sr_clr_c;
  logic                      last_in_c;
  logic                      advance_c;
  logic                      at_end_c;
  logic                      past_end_c;

  // Start delay line; cleared whenever the request drops outside IDLE.
  start_shifter #(
    .DEPTH (START_DELAY)
  ) u_start_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .en        (chip_en),
    .clr       (sr_clr_c),
    .din       (start_exec),
    .dout      (start_exec_shifted),
    .last_in_c (last_in_c)
  );

  // Next state; dropping start_exec in ARM/RUN/DONE returns to IDLE first.
  always_comb begin
    state_d  = state_q;
    sr_clr_c = 1'b0;
    if (chip_en) begin
      unique case (state_q)
        SEQ_IDLE: begin
          if (start_exec) begin
            state_d = last_in_c ? SEQ_RUN : SEQ_ARM;
          end
        end
        SEQ_ARM: begin
          if (!start_exec) begin
            state_d  = SEQ_IDLE;
            sr_clr_c = 1'b1;
          end else if (last_in_c) begin
            state_d = SEQ_RUN;
          end
        end
        SEQ_RUN: begin
          if (!start_exec) begin
            state_d  = SEQ_IDLE;
            sr_clr_c = 1'b1;
          end else if (exec_end) begin
            state_d = SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          if (!start_exec) begin
            state_d  = SEQ_IDLE;
            sr_clr_c = 1'b1;
          end
        end
        default: begin
          state_d  = SEQ_IDLE;
          sr_clr_c = 1'b1;
        end
      endcase
    end
  end

  assign at_end_c   = addr_eq_end(CMP_W'(addr_q), CMP_W'(loop_end));
  assign past_end_c = addr_ge_end(CMP_W'(addr_q), CMP_W'(loop_end));
  // The address steps only while staying in RUN on a lane-wrap cycle.
  assign advance_c  = chip_en && (state_q == SEQ_RUN) && (state_d == SEQ_RUN) && clken_q;

  // Lane counter, clock enable, address walk and status, keyed on next state.
  always_comb begin
    vec_d   = vec_q;
    clken_d = clken_q;
    addr_d  = addr_q;
    wrap_d  = 1'b0;
    done_d  = done_q;
    if (chip_en) begin
      done_d = (state_d == SEQ_DONE);
      unique case (state_d)
        SEQ_IDLE, SEQ_ARM: begin
          vec_d   = '0;
          clken_d = 1'b1;
          addr_d  = '0;
        end
        SEQ_RUN: begin
          if (state_q == SEQ_RUN) begin
            vec_d = (vec_q == vec_size) ? '0 : vec_q + VEC_WIDTH_BITS'(1);
          end else begin
            vec_d  = '0;
            addr_d = '0;
          end
          clken_d = (vec_d == vec_size);
          if (advance_c) begin
            wrap_d = at_end_c;
            if (past_end_c || (addr_q < loop_start)) begin
              addr_d = loop_start;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
        SEQ_DONE: begin
          clken_d = 1'b0;
        end
        default: begin
          vec_d   = '0;
          clken_d = 1'b1;
          addr_d  = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= SEQ_IDLE;
      vec_q   <= '0;
      clken_q <= 1'b1;
      addr_q  <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      clken_q <= clken_d;
      addr_q  <= addr_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign vec_counter = vec_q;
  assign clken_vec   = clken_q;
  assign addr_cmem   = addr_q;
  assign loop_wrap   = wrap_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cmem_sequencer.sv
// Directed plus randomized bench for cmem_sequencer against a behavioural model.
module tb_cmem_sequencer;

  localparam int unsigned CMB = 3;
  localparam int unsigned VW  = 4;
  localparam int unsigned VWB = 2;
  localparam int unsigned D   = 2;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic           clk;
  logic           rstn;
  logic           chip_en;
  logic           start_exec;
  logic [CMB:0]   loop_start;
  logic [CMB-1:0] loop_end;
  logic [VWB-1:0] vec_size;
  logic           exec_end;
  logic           start_exec_shifted;
  logic [VWB-1:0] vec_counter;
  logic           clken_vec;
  logic [CMB:0]   addr_cmem;
  logic           loop_wrap;
  logic           done;

  int tests;
  int fails;

  // Model: mode, start history, RUN edge count, address, wrap flag.
  int m_mode;
  int hist[D];
  int m_runcnt;
  int m_addr;
  int m_wrap;

  cmem_sequencer #(
    .CONFIG_MEM_BITS (CMB),
    .VEC_WIDTH       (VW),
    .START_DELAY     (D)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .chip_en            (chip_en),
    .start_exec         (start_exec),
    .loop_start         (loop_start),
    .loop_end           (loop_end),
    .vec_size           (vec_size),
    .exec_end           (exec_end),
    .start_exec_shifted (start_exec_shifted),
    .vec_counter        (vec_counter),
    .clken_vec          (clken_vec),
    .addr_cmem          (addr_cmem),
    .loop_wrap          (loop_wrap),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    for (int i = 0; i < D; i++) hist[i] = 0;
    m_runcnt = 0;
    m_addr   = 0;
    m_wrap   = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held across it.
  task automatic model_step();
    int lane;
    int nm;
    int vs;
    int ls;
    int le;
    vs = int'(vec_size);
    ls = int'(loop_start);
    le = int'(loop_end);
    if (!chip_en) begin
      m_wrap = 0;
      return;
    end
    lane = m_runcnt % (vs + 1);
    for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'(start_exec);
    nm = m_mode;
    if (m_mode != M_IDLE && !start_exec) nm = M_IDLE;
    else if (m_mode == M_IDLE && start_exec) nm = (hist[D-1] != 0) ? M_RUN : M_ARM;
    else if (m_mode == M_ARM && hist[D-1] != 0) nm = M_RUN;
    else if (m_mode == M_RUN && exec_end) nm = M_DONE;
    if (nm == M_IDLE && m_mode != M_IDLE) begin
      for (int i = 0; i < D; i++) hist[i] = 0;
    end
    m_wrap = 0;
    if (m_mode == M_RUN && nm == M_RUN) begin
      if (lane == vs) begin
        m_wrap = (m_addr == le) ? 1 : 0;
        m_addr = (m_addr >= le || m_addr < ls) ? ls : m_addr + 1;
      end
      m_runcnt++;
    end else if (nm != M_DONE) begin
      m_runcnt = 0;
      m_addr   = 0;
    end
    m_mode = nm;
  endtask

  task automatic check_all();
    int lane;
    int exp_clk;
    lane = (m_mode == M_RUN || m_mode == M_DONE) ? m_runcnt % (int'(vec_size) + 1) : 0;
    if (m_mode == M_RUN) exp_clk = (lane == int'(vec_size)) ? 1 : 0;
    else if (m_mode == M_DONE) exp_clk = 0;
    else exp_clk = 1;
    chk("start_exec_shifted", 32'(start_exec_shifted), 32'(hist[D-1]));
    chk("vec_counter", 32'(vec_counter), 32'(lane));
    chk("clken_vec", 32'(clken_vec), 32'(exp_clk));
    chk("addr_cmem", 32'(addr_cmem), 32'(m_addr));
    chk("loop_wrap", 32'(loop_wrap), 32'(m_wrap));
    chk("done", 32'(done), 32'(m_mode == M_DONE));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rstn       = 1'b0;
    chip_en    = 1'b1;
    start_exec = 1'b0;
    loop_start = 4'd1;
    loop_end   = 3'd3;
    vec_size   = 2'd0;
    exec_end   = 1'b0;
    model_reset();
    #12;
    check_all();
    #5 rstn = 1'b1;
    steps(2);

    // Basic loop: addr 0,1,2,3,1,2,3 with wrap after each 3->1.
    start_exec = 1'b1;
    step();
    step();
    chk("basic_shifted_rise", 32'(start_exec_shifted), 32'd1);
    steps(12);
    start_exec = 1'b0;
    steps(3);

    // Vector lanes: four lanes, enable only on the last lane.
    vec_size   = 2'd3;
    loop_start = 4'd0;
    loop_end   = 3'd7;
    start_exec = 1'b1;
    steps(22);

    // Completion: exec_end pulse, freeze in DONE, then release to IDLE.
    exec_end = 1'b1;
    step();
    exec_end = 1'b0;
    chk("done_clken_low", 32'(clken_vec), 32'd0);
    steps(4);
    start_exec = 1'b0;
    steps(3);

    // Abort wins over exec_end.
    vec_size   = 2'd1;
    loop_start = 4'd2;
    loop_end   = 3'd5;
    start_exec = 1'b1;
    steps(7);
    start_exec = 1'b0;
    exec_end   = 1'b1;
    step();
    exec_end = 1'b0;
    chk("abort_not_done", 32'(done), 32'd0);
    steps(2);

    // chip_en low for three cycles mid-RUN.
    vec_size   = 2'd0;
    loop_start = 4'd1;
    loop_end   = 3'd4;
    start_exec = 1'b1;
    steps(6);
    chip_en = 1'b0;
    steps(3);
    chip_en = 1'b1;
    steps(8);
    start_exec = 1'b0;
    steps(2);

    // Inverted bounds: address parks at loop_start, no wrap.
    loop_start = 4'd5;
    loop_end   = 3'd2;
    start_exec = 1'b1;
    steps(9);
    chk("bounds_stuck", 32'(addr_cmem), 32'd5);

    // Asynchronous reset in the middle of RUN.
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    start_exec = 1'b0;
    #1 rstn = 1'b1;
    steps(2);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      if (m_mode == M_IDLE) begin
        vec_size   = 2'($urandom_range(0, 3));
        loop_start = 4'($urandom_range(0, 9));
        loop_end   = 3'($urandom_range(0, 7));
        start_exec = ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 39) == 0) begin
        start_exec = 1'b0;
      end
      exec_end = ($urandom_range(0, 15) == 0);
      chip_en  = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
